// File: rtl/mostra_sequencia.sv
// Memory-game playback engine: walks jogada ROM addresses 0..limite and shows
// each entry on the LEDs as a lit pulse followed by a dark gap.
module mostra_sequencia #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TMAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TA_FIM = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] TP_FIM = TW'(T_APAGADO - 1);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ENDERECA = 4'd1,
    CARREGA  = 4'd2,
    ACESO    = 4'd3,
    APAGADO  = 4'd4,
    PROXIMO  = 4'd5,
    FIM      = 4'd6
  } estado_t;

  estado_t       estado, estado_prox;
  logic [3:0]    limite_reg;
  logic [3:0]    padrao;
  logic [3:0]    addr;
  logic [TW-1:0] timer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

  // parar overrides every transition, including a simultaneous iniciar
  always_comb begin
    estado_prox = INICIAL;
    if (!parar) begin
      case (estado)
        INICIAL:  estado_prox = iniciar ? ENDERECA : INICIAL;
        ENDERECA: estado_prox = CARREGA;
        CARREGA:  estado_prox = ACESO;
        ACESO:    estado_prox = (timer == TA_FIM) ? APAGADO : ACESO;
        APAGADO:  estado_prox = (timer == TP_FIM) ? PROXIMO : APAGADO;
        PROXIMO:  estado_prox = (addr == limite_reg) ? FIM : ENDERECA;
        FIM:      estado_prox = INICIAL;
        default:  estado_prox = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limite_reg <= '0;
      padrao     <= '0;
      addr       <= '0;
      timer      <= '0;
    end else begin
      // Address returns to 0 whenever the engine goes idle (end, abort, start)
      if (estado_prox == INICIAL)
        addr <= '0;
      else if (estado == PROXIMO && estado_prox == ENDERECA)
        addr <= addr + 4'd1;

      if (estado == INICIAL && estado_prox == ENDERECA)
        limite_reg <= limite;

      if (estado == CARREGA)
        padrao <= dado;

      // Timer runs only while dwelling in a timed state; any exit clears it
      if ((estado == ACESO || estado == APAGADO) && estado_prox == estado)
        timer <= timer + TW'(1);
      else
        timer <= '0;
    end
  end

  assign endereco  = addr;
  assign leds      = (estado == ACESO) ? padrao : 4'd0;
  assign ocupado   = (estado != INICIAL);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_mostra_sequencia.sv
// Bench for mostra_sequencia: behavioural ROM, cycle-indexed playback model
// compared every cycle, plus literal timing points for T_ACESO=3, T_APAGADO=2.
module tb_mostra_sequencia;

  localparam int TA = 3;
  localparam int TP = 2;
  localparam int N  = 3 + TA + TP;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       parar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado;
  logic [3:0] endereco, leds, db_estado;
  logic       ocupado, pronto;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] rom [16];

  mostra_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .limite(limite), .dado(dado), .endereco(endereco), .leds(leds),
    .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) dado <= rom[endereco];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected outputs at cycle offset c from an accepted start with k entries
  function automatic void model_at(input int c, input int k,
                                   output logic [3:0] e_st, output logic [3:0] e_leds,
                                   output logic [3:0] e_end, output logic e_oc,
                                   output logic e_pr);
    int j, r;
    e_st = 0; e_leds = 0; e_end = 0; e_oc = 0; e_pr = 0;
    if (c >= 1 && c <= k * N + 1) begin
      e_oc = 1;
      if (c == k * N + 1) begin
        e_st = 6; e_pr = 1; e_end = 4'(k - 1);
      end else begin
        j = (c - 1) / N;
        r = (c - 1) % N;
        e_end = 4'(j);
        if (r == 0)                e_st = 1;
        else if (r == 1)           e_st = 2;
        else if (r < 2 + TA)       e_st = 3;
        else if (r < 2 + TA + TP)  e_st = 4;
        else                       e_st = 5;
        if (e_st == 3) e_leds = rom[j];
      end
    end
  endfunction

  int  m_t0 = 0;
  int  m_k = 1;
  bit  m_active = 0;

  always @(negedge clock) begin
    logic [3:0] e_st, e_leds, e_end;
    logic       e_oc, e_pr;
    if (!reset) begin
      m_active = 0;
      e_st = 0; e_leds = 0; e_end = 0; e_oc = 0; e_pr = 0;
    end else if (m_active) begin
      model_at(cyc - m_t0, m_k, e_st, e_leds, e_end, e_oc, e_pr);
    end else begin
      e_st = 0; e_leds = 0; e_end = 0; e_oc = 0; e_pr = 0;
    end
    chk("db_estado", int'(db_estado), int'(e_st));
    chk("leds", int'(leds), int'(e_leds));
    chk("endereco", int'(endereco), int'(e_end));
    chk("ocupado", int'(ocupado), int'(e_oc));
    chk("pronto", int'(pronto), int'(e_pr));
    if (reset) begin
      if (parar) m_active = 0;
      else if (e_st == 0 && iniciar) begin
        m_active = 1; m_t0 = cyc; m_k = int'(limite) + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while (cyc < target && n < 2000) begin tick; n++; end
    if (cyc != target) chk("wait_cycle_reached", cyc, target);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (ocupado && n < 500) begin tick; n++; end
    if (ocupado) chk("idle_timeout", 1, 0);
    tick;
  endtask

  task automatic start_run(input logic [3:0] lim, output int t0);
    limite = lim;
    iniciar = 1'b1;
    t0 = cyc;
    tick;
    iniciar = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));

    // reset state
    #3;
    chk("rst_leds", int'(leds), 0);
    chk("rst_endereco", int'(endereco), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_estado", int'(db_estado), 0);
    tick; tick;
    reset = 1'b1;
    tick; tick;

    // limite=0: single entry
    start_run(4'd0, t);
    wait_cycle(t + 2); chk("a_leds_c2", int'(leds), 0);
    wait_cycle(t + 3); chk("a_leds_c3", int'(leds), 1);
    wait_cycle(t + 5); chk("a_leds_c5", int'(leds), 1);
    wait_cycle(t + 6); chk("a_leds_c6", int'(leds), 0);
    wait_cycle(t + 9); chk("a_pronto_c9", int'(pronto), 1);
    chk("a_ocupado_c9", int'(ocupado), 1);
    wait_cycle(t + 10); chk("a_ocupado_c10", int'(ocupado), 0);
    wait_idle;

    // limite=3, with iniciar re-pulse and limite change mid-run
    start_run(4'd3, t);
    wait_cycle(t + 5); iniciar = 1'b1; tick; iniciar = 1'b0;
    wait_cycle(t + 7); limite = 4'd0;
    wait_cycle(t + 11); chk("b_leds_c11", int'(leds), 2);
    wait_cycle(t + 19); chk("b_leds_c19", int'(leds), 4);
    wait_cycle(t + 27); chk("b_leds_c27", int'(leds), 8);
    wait_cycle(t + 32); chk("b_end_c32", int'(endereco), 3);
    wait_cycle(t + 33); chk("b_pronto_c33", int'(pronto), 1);
    chk("b_end_c33", int'(endereco), 3);
    wait_cycle(t + 34); chk("b_estado_c34", int'(db_estado), 0);
    chk("b_end_c34", int'(endereco), 0);
    wait_idle;

    // limite=15, last entry 1111
    rom[15] = 4'hF;
    start_run(4'd15, t);
    wait_cycle(t + 122); chk("c_leds_c122", int'(leds), 0);
    wait_cycle(t + 123); chk("c_leds_c123", int'(leds), 15);
    chk("c_end_c123", int'(endereco), 15);
    wait_cycle(t + 125); chk("c_leds_c125", int'(leds), 15);
    wait_cycle(t + 129); chk("c_pronto_c129", int'(pronto), 1);
    wait_idle;
    rom[15] = 4'h8;

    // zero ROM entry shown dark, timing unchanged
    rom[1] = 4'h0;
    start_run(4'd2, t);
    wait_cycle(t + 11); chk("d_leds_c11", int'(leds), 0);
    chk("d_estado_c11", int'(db_estado), 3);
    wait_cycle(t + 25); chk("d_pronto_c25", int'(pronto), 1);
    wait_idle;
    rom[1] = 4'h2;

    // parar in cycle 12
    start_run(4'd3, t);
    wait_cycle(t + 12); parar = 1'b1; tick; parar = 1'b0;
    chk("e_estado_c13", int'(db_estado), 0);
    chk("e_leds_c13", int'(leds), 0);
    chk("e_end_c13", int'(endereco), 0);
    wait_cycle(t + 40);
    chk("e_ocupado_c40", int'(ocupado), 0);

    // parar and iniciar together in INICIAL
    limite = 4'd1; iniciar = 1'b1; parar = 1'b1;
    tick;
    iniciar = 1'b0; parar = 1'b0;
    chk("f_estado", int'(db_estado), 0);
    chk("f_ocupado", int'(ocupado), 0);
    tick; tick;

    // asynchronous reset mid-ACESO
    start_run(4'd3, t);
    wait_cycle(t + 4);
    chk("g_leds_before", int'(leds), 1);
    #1 reset = 1'b0;
    #1;
    chk("g_leds_async", int'(leds), 0);
    chk("g_estado_async", int'(db_estado), 0);
    tick;
    reset = 1'b1;
    tick; tick;
    start_run(4'd0, t);
    wait_cycle(t + 3); chk("h_leds_c3", int'(leds), 1);
    wait_cycle(t + 9); chk("h_pronto_c9", int'(pronto), 1);
    wait_idle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mostra_sequencia.md
# mostra_sequencia

Playback engine for the memory game: on command, reads the stored sequence from the synchronous 16x4 jogada ROM, address 0 through a latched limit, and shows each entry on the LEDs as a timed lit/dark pulse. It is the presenting side of the round: it drives the ROM and LEDs that the player-response datapath later compares botoes against. It sits beside that datapath under the game's top-level controller, which pulses `iniciar` and waits for `pronto`.

## Interface
- T_ACESO, 500: cycles an entry stays lit (0.5 s at 1 kHz); must be >= 1.
- T_APAGADO, 250: dark cycles after each entry; must be >= 1.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; forces INICIAL and all outputs to reset values.
- iniciar  in  1  start request; sampled only in INICIAL.
- parar  in  1  synchronous abort; next state INICIAL from any state, no `pronto`.
- limite  in  4  index of last entry to show, inclusive; latched on accepted `iniciar`.
- dado  in  4  ROM data_out; valid one cycle after `endereco` is presented.
- endereco  out  4  ROM address.
- leds  out  4  displayed pattern.
- ocupado  out  1  high in every state except INICIAL.
- pronto  out  1  one-cycle pulse when the sequence completes normally.
- db_estado  out  4  state code, for debug.

## Operation
- States and codes: INICIAL=0, ENDERECA=1, CARREGA=2, ACESO=3, APAGADO=4, PROXIMO=5, FIM=6. Codes 7-15 are unused; if reached, the next state is INICIAL.
- INICIAL: `endereco` holds 0, `leds`=0. On `iniciar`=1 and `parar`=0:
  - latch `limite` into limite_reg;
  - clear the address counter;
  - go to ENDERECA.
- ENDERECA: `endereco` is presented; the ROM samples it at this cycle's edge. Next state is CARREGA.
- CARREGA: `dado` is valid; load it into the 4-bit padrao register. Clear the timer. Next state is ACESO.
- ACESO: `leds`=padrao for exactly T_ACESO cycles; the timer counts. When the timer reaches T_ACESO-1, clear the timer and go to APAGADO.
- APAGADO: `leds`=0 for exactly T_APAGADO cycles, then go to PROXIMO.
- PROXIMO:
  - if endereco == limite_reg, go to FIM;
  - otherwise increment endereco and go to ENDERECA.
- FIM: `pronto`=1 for this cycle only. Next state is INICIAL.
- Mid-run changes to `limite` have no effect. `iniciar` outside INICIAL is ignored.
- `parar` has priority over every other transition. Effect on the next cycle:
  - `leds`=0, `ocupado`=0;
  - `endereco` cleared to 0;
  - `pronto` not asserted.
- If `parar` and `iniciar` are both high in INICIAL, the block stays in INICIAL.
- A ROM entry of 0000 is shown as dark for T_ACESO cycles; this is not an error.
- limite_reg=15 shows all 16 entries. The address counter never wraps, because PROXIMO exits at equality before incrementing.
- Timer width is wide enough for max(T_ACESO, T_APAGADO)-1.

## Timing
- Reset values: `leds`=0, `endereco`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, padrao=0, limite_reg=0, timer=0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Per-entry period N = 3 + T_ACESO + T_APAGADO cycles (ENDERECA + CARREGA + lit + dark + PROXIMO).
- Take cycle 0 as the cycle in which `iniciar` is sampled high in INICIAL. With k = limite+1:
  - entry j is in ENDERECA in cycle 1 + j·N;
  - entry j is lit in cycles 3 + j·N through 2 + j·N + T_ACESO;
  - `pronto` is high in cycle k·N + 1;
  - `ocupado` is high in cycles 1 through k·N + 1;
  - the earliest next `iniciar` that can be accepted is in cycle k·N + 2.
- `reset` is asynchronous: it takes effect immediately, including mid-ACESO, and `leds` drop to 0 without waiting for a clock edge. Operation resumes on the first edge after release.

## Test plan
- Bench setup: T_ACESO=3, T_APAGADO=2, so N=8. Behavioural ROM with 1-cycle latency, contents addr i → 0001, 0010, 0100, 1000 repeating.
- limite=0, `iniciar` pulse in cycle 0 → `leds`=0001 in cycles 3-5, 0 otherwise. `pronto` high only in cycle 9; `ocupado` high in cycles 1-9.
- limite=3 → `leds` shows 0001, 0010, 0100, 1000 starting at cycles 3, 11, 19, 27, each for 3 cycles with 0 between. `pronto` in cycle 33. `endereco` ends at 3, never 4.
- limite=15 with ROM address 15 holding 1111 → 16 entries shown, last lit in cycles 123-125, `pronto` in cycle 129. `endereco` never wraps to 0 before FIM.
- Abort cases:
  - `parar` in cycle 12 of a limite=3 run → cycle 13 in INICIAL, `leds`=0, `endereco`=0, `pronto` never asserted.
  - `parar` and `iniciar` together in INICIAL → no start.
- Corner cases:
  - `reset` low in cycle 4 (mid-ACESO) → `leds`=0 and `db_estado`=0 before the next edge.
  - `limite` changed from 3 to 0 during a run → 4 entries still shown.
  - `iniciar` re-pulsed while `ocupado` → ignored.
  - ROM entry 0000 → dark for the lit window, timing unchanged.
